// File: rtl/argmax_arbiter.sv
// Round-robin arbiter that lets M requesters share a single argmax unit.
// One transaction at a time: accept vector, forward it, wait for the index, return it.
module argmax_arbiter #(
  parameter int N  = 2,
  parameter int M  = 2,
  parameter int IW = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [M-1:0][N-1:0][31:0]   req_v,
  input  logic [M-1:0]                req_stb,
  output logic [M-1:0]                req_ack,
  output logic [IW-1:0]               res_i,
  output logic [M-1:0]                res_stb,
  input  logic [M-1:0]                res_ack,
  output logic [N-1:0][31:0]          am_v,
  output logic                        am_v_stb,
  input  logic                        am_v_ack,
  input  logic [IW-1:0]               am_i,
  input  logic                        am_i_stb,
  output logic                        am_i_ack,
  output logic [$clog2(M)-1:0]        grant_id,
  output logic                        busy,
  output logic [15:0]                 done_cnt
);
  localparam int GW = $clog2(M);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_SEND,
    S_WAIT,
    S_RETURN
  } state_t;

  state_t               r_state,    w_state_next;
  logic [GW-1:0]        r_ptr,      w_ptr_next;
  logic [GW-1:0]        r_grant,    w_grant_next;
  logic [M-1:0]         r_req_ack,  w_req_ack_next;
  logic [M-1:0]         r_res_stb,  w_res_stb_next;
  logic                 r_am_v_stb, w_am_v_stb_next;
  logic                 r_am_i_ack, w_am_i_ack_next;
  logic                 r_busy,     w_busy_next;
  logic [IW-1:0]        r_res_i,    w_res_i_next;
  logic [N-1:0][31:0]   r_am_v,     w_am_v_next;
  logic [15:0]          r_done_cnt, w_done_cnt_next;

  logic [GW:0]          w_idx;
  logic [GW-1:0]        w_sel;
  logic                 w_sel_found;
  logic [GW-1:0]        w_ptr_wrap;

  // First requester with strobe high, scanning from r_ptr upward modulo M.
  always_comb begin
    w_sel       = '0;
    w_sel_found = 1'b0;
    w_idx       = '0;
    for (int k = 0; k < M; k++) begin
      w_idx = {1'b0, r_ptr} + (GW+1)'(k);
      if (w_idx >= (GW+1)'(M)) begin
        w_idx = w_idx - (GW+1)'(M);
      end
      if (!w_sel_found && req_stb[w_idx[GW-1:0]]) begin
        w_sel_found = 1'b1;
        w_sel       = w_idx[GW-1:0];
      end
    end
  end

  assign w_ptr_wrap = (r_grant == GW'(M-1)) ? '0 : r_grant + GW'(1);

  always_comb begin
    w_state_next    = r_state;
    w_ptr_next      = r_ptr;
    w_grant_next    = r_grant;
    w_req_ack_next  = r_req_ack;
    w_res_stb_next  = r_res_stb;
    w_am_v_stb_next = r_am_v_stb;
    w_am_i_ack_next = r_am_i_ack;
    w_res_i_next    = r_res_i;
    w_am_v_next     = r_am_v;
    w_done_cnt_next = r_done_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_sel_found) begin
          w_grant_next   = w_sel;
          w_req_ack_next = M'(1) << w_sel;
          w_state_next   = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (req_stb[r_grant] && r_req_ack[r_grant]) begin
          w_am_v_next     = req_v[r_grant];
          w_req_ack_next  = '0;
          w_am_v_stb_next = 1'b1;
          w_state_next    = S_SEND;
        end
      end
      S_SEND: begin
        if (r_am_v_stb && am_v_ack) begin
          w_am_v_stb_next = 1'b0;
          w_am_i_ack_next = 1'b1;
          w_state_next    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (am_i_stb && r_am_i_ack) begin
          w_res_i_next    = am_i;
          w_am_i_ack_next = 1'b0;
          w_res_stb_next  = M'(1) << r_grant;
          w_state_next    = S_RETURN;
        end
      end
      S_RETURN: begin
        // Only the granted requester's accept can complete the transaction.
        if (res_ack[r_grant] && r_res_stb[r_grant]) begin
          w_res_stb_next  = '0;
          w_ptr_next      = w_ptr_wrap;
          w_done_cnt_next = r_done_cnt + 16'd1;
          w_state_next    = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    w_busy_next = (w_state_next != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_req_ack  <= '0;
      r_res_stb  <= '0;
      r_am_v_stb <= 1'b0;
      r_am_i_ack <= 1'b0;
      r_busy     <= 1'b0;
      r_res_i    <= '0;
      r_am_v     <= '0;
      r_done_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_ptr      <= w_ptr_next;
      r_grant    <= w_grant_next;
      r_req_ack  <= w_req_ack_next;
      r_res_stb  <= w_res_stb_next;
      r_am_v_stb <= w_am_v_stb_next;
      r_am_i_ack <= w_am_i_ack_next;
      r_busy     <= w_busy_next;
      r_res_i    <= w_res_i_next;
      r_am_v     <= w_am_v_next;
      r_done_cnt <= w_done_cnt_next;
    end
  end

  assign req_ack  = r_req_ack;
  assign res_stb  = r_res_stb;
  assign am_v_stb = r_am_v_stb;
  assign am_i_ack = r_am_i_ack;
  assign busy     = r_busy;
  assign res_i    = r_res_i;
  assign am_v     = r_am_v;
  assign grant_id = r_grant;
  assign done_cnt = r_done_cnt;

endmodule

// File: doc/argmax_arbiter.md
ARGMAX_ARBITER -- requirements
Module: argmax_arbiter

Interface
REQ-001 SHALL have parameter N, default 2: vector length, passed through to the shared argmax unit.
REQ-002 SHALL have parameter M, default 2: number of requesters (M >= 2).
REQ-003 SHALL have parameter IW, default 32: index width, equal to the argmax output_i width.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_v  in  M x N x 32  per-requester float32 vector.
REQ-007 SHALL have port req_stb  in  M  per-requester request strobe.
REQ-008 SHALL have port req_ack  out  M  per-requester request accept.
REQ-009 SHALL have port res_i  out  IW  returned argmax index, shared by all requesters.
REQ-010 SHALL have port res_stb  out  M  per-requester result valid.
REQ-011 SHALL have port res_ack  in  M  per-requester result accept.
REQ-012 SHALL have port am_v  out  N x 32  vector to the argmax unit.
REQ-013 SHALL have port am_v_stb / am_v_ack  out / in  1 / 1  argmax input handshake.
REQ-014 SHALL have port am_i  in  IW  index from the argmax unit.
REQ-015 SHALL have port am_i_stb / am_i_ack  in / out  1 / 1  argmax output handshake.
REQ-016 SHALL have port grant_id  out  $clog2(M)  index of the requester being served.
REQ-017 SHALL have port busy  out  1  high in every state except IDLE.
REQ-018 SHALL have port done_cnt  out  16  count of completed transactions, wraps at 16'hFFFF -> 0.

Function
REQ-019 SHALL use a transfer rule for every handshake: transfer occurs on the rising edge where stb and ack are both 1; the source holds stb and data stable until then.
REQ-020 SHALL implement states IDLE, ACCEPT, SEND, WAIT, RETURN; all outputs are registered.
REQ-021 SHALL, in IDLE with any req_stb high, select g as the first requester with req_stb high, scanning ptr, ptr+1, ... mod M; register grant_id=g, set req_ack[g]=1, and go to ACCEPT.
REQ-022 SHALL, in ACCEPT, on transfer, capture req_v[g] into am_v, clear req_ack[g], set am_v_stb=1, and go to SEND.
REQ-023 SHALL, in SEND, on am_v transfer, clear am_v_stb, set am_i_ack=1, and go to WAIT.
REQ-024 SHALL, in WAIT, on am_i transfer, register res_i=am_i, clear am_i_ack, set res_stb[g]=1, and go to RETURN.
REQ-025 SHALL, in RETURN, on res transfer with res_ack[g], clear res_stb[g], set ptr=(g+1) mod M including wrap M-1 -> 0, increment done_cnt, and go to IDLE.
REQ-026 SHALL have at most one bit of req_ack and at most one bit of res_stb high at any time, and only bit g.
REQ-027 SHALL ignore req_stb of non-granted requesters outside IDLE; they wait with no ack.
REQ-028 SHALL ignore res_ack of non-granted requesters and res_ack[g] outside RETURN.
REQ-029 SHALL wait indefinitely in every state for its peer; there is no timeout.
REQ-030 SHALL, for simultaneous requests, serve requesters round-robin: each requester with req_stb held is granted within M transactions.
REQ-031 SHALL give minimum latency of 4 cycles from req_stb to res_stb, plus argmax compute time and peer ack delays. The bound for REQ-030 follows from REQ-021 and REQ-025.
REQ-032 SHALL leave res_i and am_v holding their last values between transactions.

Reset
REQ-033 SHALL, while rst=0 at any time including mid-transaction, force state=IDLE, ptr=0, grant_id=0, and req_ack, res_stb, am_v_stb, am_i_ack, busy, res_i, am_v, done_cnt all 0.
REQ-034 SHALL NOT drive the argmax unit's reset; the system resets both blocks together, and an in-flight transaction is discarded without a response.

Verification
REQ-035 SHALL be verified with a single request, N=4, M=2: req_v[0]={1.0,3.0,2.0,0.5}, unit returns 1 -> res_stb[0] with res_i=1, done_cnt=1, ptr=1.
REQ-036 SHALL be verified with simultaneous requests, M=3: all req_stb high from reset -> grants in order 0,1,2, then 0 again when re-requested; done_cnt=3 after three.
REQ-037 SHALL be verified for wrap: ptr=2 (M=3) with req_stb={1,1,0} for requesters 0,1 -> requester 0 granted first.
REQ-038 SHALL be verified under backpressure: am_v_ack delayed 5 cycles and res_ack[g] delayed 7 cycles -> state holds, stb stays high, no other ack or stb asserted.
REQ-039 SHALL be verified for reset mid-operation: rst=0 asserted in WAIT -> all outputs 0 asynchronously; after release a new request is served normally, done_cnt counting from 0.
REQ-040 SHALL be verified for counter wrap: done_cnt preloaded by 65535 transactions, then one more completes -> done_cnt=0.
